// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU op codes,
// ID/EX control bit positions and the ID/EX pipeline bundle.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam int CTRL_REGWRITE = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_BRANCH   = 1;
    localparam int CTRL_JUMP     = 0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [1:0]      alu_op;
        logic [6:0]      ctrl;
    } id_ex_t;

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/regfile.sv
// RV32I register file: two async read ports with write-through,
// one sync write port, x0 hardwired to zero, async active-low clear.
module regfile
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic            wr_en;

    assign wr_en = we_i && (waddr_i != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A same-cycle writeback must be visible to the decoding instruction
    always_comb begin
        rdata1_o = mem_q[raddr1_i];
        rdata2_o = mem_q[raddr2_i];
        if (wr_en && waddr_i == raddr1_i) rdata1_o = wdata_i;
        if (wr_en && waddr_i == raddr2_i) rdata2_o = wdata_i;
        if (raddr1_i == 5'd0) rdata1_o = '0;
        if (raddr2_i == 5'd0) rdata2_o = '0;
    end

endmodule

// File: rtl/stage2_decode.sv
// Decode stage: register read, immediate/control generation,
// load-use hazard detection and the ID/EX pipeline register.
module stage2_decode
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ifidINST,
    input  logic [XLEN-1:0] ifidPc,
    input  logic            flush,
    input  logic            wbRegWrite,
    input  logic [4:0]      wbRd,
    input  logic [XLEN-1:0] wbData,
    output logic            pcWrite,
    output logic            ifidWrite,
    output logic [XLEN-1:0] idexPc,
    output logic [XLEN-1:0] idexRs1Data,
    output logic [XLEN-1:0] idexRs2Data,
    output logic [XLEN-1:0] idexImm,
    output logic [4:0]      idexRs1,
    output logic [4:0]      idexRs2,
    output logic [4:0]      idexRd,
    output logic [2:0]      idexFunct3,
    output logic            idexFunct7b5,
    output logic [1:0]      idexAluOp,
    output logic [6:0]      idexCtrl
);

    id_ex_t idex_q, idex_d;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] imm;
    logic [6:0]      ctrl;
    logic [1:0]      alu_op;
    logic            stall;

    assign opcode = ifidINST[6:0];
    assign rs1    = ifidINST[19:15];
    assign rs2    = ifidINST[24:20];

    regfile u_regfile (
        .clk      (clk),
        .rst_n    (reset),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data),
        .we_i     (wbRegWrite),
        .waddr_i  (wbRd),
        .wdata_i  (wbData)
    );

    always_comb begin
        imm    = '0;
        ctrl   = '0;
        alu_op = ALUOP_ADD;
        unique case (1'b1)
            (opcode == OP_R): begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                alu_op = ALUOP_FUNC;
            end
            (opcode == OP_IMM): begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                alu_op = ALUOP_FUNC;
                imm = {{20{ifidINST[31]}}, ifidINST[31:20]};
            end
            (opcode == OP_LOAD): begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_MEMREAD]  = 1'b1;
                ctrl[CTRL_MEMTOREG] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                imm = {{20{ifidINST[31]}}, ifidINST[31:20]};
            end
            (opcode == OP_STORE): begin
                ctrl[CTRL_MEMWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                imm = {{20{ifidINST[31]}}, ifidINST[31:25],
                       ifidINST[11:7]};
            end
            (opcode == OP_BRANCH): begin
                ctrl[CTRL_BRANCH] = 1'b1;
                alu_op = ALUOP_BR;
                imm = {{20{ifidINST[31]}}, ifidINST[7],
                       ifidINST[30:25], ifidINST[11:8], 1'b0};
            end
            (opcode == OP_JAL): begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_JUMP]     = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                imm = {{12{ifidINST[31]}}, ifidINST[19:12],
                       ifidINST[20], ifidINST[30:21], 1'b0};
            end
            (opcode == OP_JALR): begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_JUMP]     = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                imm = {{20{ifidINST[31]}}, ifidINST[31:20]};
            end
            (opcode == OP_LUI),
            (opcode == OP_AUIPC): begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                imm = {ifidINST[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    // A load in EX whose result is needed now costs one bubble
    assign stall = idex_q.ctrl[CTRL_MEMREAD]
                && (idex_q.rd != 5'd0)
                && ((idex_q.rd == rs1)
                 || ((idex_q.rd == rs2) && uses_rs2(opcode)));

    assign pcWrite   = stall && !flush;
    assign ifidWrite = stall && !flush;

    always_comb begin
        idex_d = '0;
        if (!(flush || stall || ifidINST == NOP_INST)) begin
            idex_d.pc       = ifidPc;
            idex_d.rs1_data = rs1_data;
            idex_d.rs2_data = rs2_data;
            idex_d.imm      = imm;
            idex_d.rs1      = rs1;
            idex_d.rs2      = rs2;
            idex_d.rd       = ifidINST[11:7];
            idex_d.funct3   = ifidINST[14:12];
            idex_d.funct7b5 = ifidINST[30];
            idex_d.alu_op   = alu_op;
            idex_d.ctrl     = ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign idexPc       = idex_q.pc;
    assign idexRs1Data  = idex_q.rs1_data;
    assign idexRs2Data  = idex_q.rs2_data;
    assign idexImm      = idex_q.imm;
    assign idexRs1      = idex_q.rs1;
    assign idexRs2      = idex_q.rs2;
    assign idexRd       = idex_q.rd;
    assign idexFunct3   = idex_q.funct3;
    assign idexFunct7b5 = idex_q.funct7b5;
    assign idexAluOp    = idex_q.alu_op;
    assign idexCtrl     = idex_q.ctrl;

endmodule

// File: tb/tb_stage2_decode.sv
// Self-checking bench for stage2_decode: directed tables, corner
// sequences and randomized stimulus against a behavioural model.
module tb_stage2_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ifidINST, ifidPc;
    logic        flush, wbRegWrite;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic        pcWrite, ifidWrite;
    logic [31:0] idexPc, idexRs1Data, idexRs2Data, idexImm;
    logic [4:0]  idexRs1, idexRs2, idexRd;
    logic [2:0]  idexFunct3;
    logic        idexFunct7b5;
    logic [1:0]  idexAluOp;
    logic [6:0]  idexCtrl;

    stage2_decode dut (
        .clk          (clk),
        .reset        (reset),
        .ifidINST     (ifidINST),
        .ifidPc       (ifidPc),
        .flush        (flush),
        .wbRegWrite   (wbRegWrite),
        .wbRd         (wbRd),
        .wbData       (wbData),
        .pcWrite      (pcWrite),
        .ifidWrite    (ifidWrite),
        .idexPc       (idexPc),
        .idexRs1Data  (idexRs1Data),
        .idexRs2Data  (idexRs2Data),
        .idexImm      (idexImm),
        .idexRs1      (idexRs1),
        .idexRs2      (idexRs2),
        .idexRd       (idexRd),
        .idexFunct3   (idexFunct3),
        .idexFunct7b5 (idexFunct7b5),
        .idexAluOp    (idexAluOp),
        .idexCtrl     (idexCtrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [1:0]  alu;
        logic [6:0]  ctrl;
        bit          bub;
    } rec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [6:0]  ctrl;
        logic [1:0]  alu;
        logic        f7;
    } vec_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] regs [32];
    rec_t        exp_r;
    bit          exp_hold;
    logic        mid_pcw, mid_ifw;
    logic [31:0] pc_v = 32'h1000;
    vec_t        tbl [15];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    function automatic rec_t bubble();
        rec_t r;
        r = '{default: '0};
        r.bub = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] sx(input int v);
        return 32'(v);
    endfunction

    // Decode straight from the ISA field definitions
    function automatic rec_t decode(input logic [31:0] in,
                                    input logic [31:0] pc,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        rec_t r;
        logic [11:0] i12, s12;
        logic [12:0] b13;
        logic [20:0] j21;
        r = '{default: '0};
        r.pc = pc; r.a = a; r.b = b;
        r.rs1 = in[19:15]; r.rs2 = in[24:20]; r.rd = in[11:7];
        r.f3 = in[14:12]; r.f7 = in[30];
        i12 = in[31:20];
        s12 = {in[31:25], in[11:7]};
        b13 = {in[31], in[7], in[30:25], in[11:8], 1'b0};
        j21 = {in[31], in[19:12], in[20], in[30:21], 1'b0};
        case (in[6:0])
            7'h33: begin r.ctrl = 7'b1000000; r.alu = 2; end
            7'h13: begin r.ctrl = 7'b1000100; r.alu = 2;
                         r.imm = sx(int'($signed(i12))); end
            7'h03: begin r.ctrl = 7'b1101100;
                         r.imm = sx(int'($signed(i12))); end
            7'h23: begin r.ctrl = 7'b0010100;
                         r.imm = sx(int'($signed(s12))); end
            7'h63: begin r.ctrl = 7'b0000010; r.alu = 1;
                         r.imm = sx(int'($signed(b13))); end
            7'h6F: begin r.ctrl = 7'b1000101;
                         r.imm = sx(int'($signed(j21))); end
            7'h67: begin r.ctrl = 7'b1000101;
                         r.imm = sx(int'($signed(i12))); end
            7'h37, 7'h17: begin r.ctrl = 7'b1000100;
                         r.imm = in & 32'hFFFF_F000; end
            default: ;
        endcase
        return r;
    endfunction

    // Called at posedge+1; returns at the next posedge+1
    task automatic step(input logic [31:0] in, input logic fl,
                        input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd);
        rec_t n;
        logic [4:0] r1, r2;
        logic [31:0] a, b;
        bit st, us2;
        ifidINST = in; ifidPc = pc_v; flush = fl;
        wbRegWrite = we; wbRd = wrd; wbData = wd;
        #3;
        r1 = in[19:15]; r2 = in[24:20];
        us2 = (in[6:0] == 7'h33) || (in[6:0] == 7'h23)
           || (in[6:0] == 7'h63);
        st = exp_r.ctrl[5] && exp_r.rd != 0
          && (exp_r.rd == r1 || (exp_r.rd == r2 && us2));
        exp_hold = st && !fl;
        mid_pcw = pcWrite; mid_ifw = ifidWrite;
        chk("pcWrite", 32'(pcWrite), 32'(exp_hold));
        chk("ifidWrite", 32'(ifidWrite), 32'(exp_hold));
        a = (r1 == 0) ? 32'h0 : (we && wrd == r1) ? wd : regs[r1];
        b = (r2 == 0) ? 32'h0 : (we && wrd == r2) ? wd : regs[r2];
        if (fl || st || in == 32'h13) n = bubble();
        else n = decode(in, pc_v, a, b);
        @(posedge clk);
        if (we && wrd != 0) regs[wrd] = wd;
        exp_r = n;
        #1;
        chk("idexCtrl", 32'(idexCtrl), 32'(exp_r.ctrl));
        chk("idexRd", 32'(idexRd), 32'(exp_r.rd));
        if (!exp_r.bub) begin
            chk("idexPc", idexPc, exp_r.pc);
            chk("idexRs1Data", idexRs1Data, exp_r.a);
            chk("idexRs2Data", idexRs2Data, exp_r.b);
            chk("idexImm", idexImm, exp_r.imm);
            chk("idexRs1", 32'(idexRs1), 32'(exp_r.rs1));
            chk("idexRs2", 32'(idexRs2), 32'(exp_r.rs2));
            chk("idexFunct3", 32'(idexFunct3), 32'(exp_r.f3));
            chk("idexFunct7b5", 32'(idexFunct7b5), 32'(exp_r.f7));
            chk("idexAluOp", 32'(idexAluOp), 32'(exp_r.alu));
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_pcWrite"}, 32'(pcWrite), 32'h0);
        chk({nm, "_ifidWrite"}, 32'(ifidWrite), 32'h0);
        chk({nm, "_pc"}, idexPc, 32'h0);
        chk({nm, "_rs1d"}, idexRs1Data, 32'h0);
        chk({nm, "_rs2d"}, idexRs2Data, 32'h0);
        chk({nm, "_imm"}, idexImm, 32'h0);
        chk({nm, "_idx"}, 32'({idexRs1, idexRs2, idexRd}), 32'h0);
        chk({nm, "_f"}, 32'({idexFunct3, idexFunct7b5, idexAluOp}),
            32'h0);
        chk({nm, "_ctrl"}, 32'(idexCtrl), 32'h0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        exp_r = bubble();
        exp_hold = 0;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] LW9 = 32'h0000_A483;
    localparam logic [31:0] ADD10 = 32'h0024_8533;

    initial begin
        logic [6:0]  ops [11];
        logic [31:0] cur;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                7'h37, 7'h17, 7'h0F, 7'h7F};
        tbl[0]  = '{32'h0002_8333, 32'h0,         7'h40, 2'd2, 1'b0};
        tbl[1]  = '{32'hFFF3_8413, 32'hFFFF_FFFF, 7'h44, 2'd2, 1'b1};
        tbl[2]  = '{32'hFE31_2C23, 32'hFFFF_FFF8, 7'h14, 2'd0, 1'b1};
        tbl[3]  = '{32'h0010_00EF, 32'h0000_0800, 7'h45, 2'd0, 1'b0};
        tbl[4]  = '{32'hABCD_E237, 32'hABCD_E000, 7'h44, 2'd0, 1'b0};
        tbl[5]  = '{LW9,           32'h0,         7'h6C, 2'd0, 1'b0};
        tbl[6]  = '{ADD10,         32'h0,         7'h40, 2'd2, 1'b0};
        tbl[7]  = '{32'h0020_8463, 32'h0000_0008, 7'h02, 2'd1, 1'b0};
        tbl[8]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 7'h02, 2'd1, 1'b1};
        tbl[9]  = '{32'h0042_80E7, 32'h0000_0004, 7'h45, 2'd0, 1'b0};
        tbl[10] = '{32'h1234_5197, 32'h1234_5000, 7'h44, 2'd0, 1'b0};
        tbl[11] = '{32'hFFF0_2083, 32'hFFFF_FFFF, 7'h6C, 2'd0, 1'b1};
        tbl[12] = '{32'h0000_007F, 32'h0,         7'h00, 2'd0, 1'b0};
        tbl[13] = '{32'h0000_000F, 32'h0,         7'h00, 2'd0, 1'b0};
        tbl[14] = '{32'h4031_00B3, 32'h0,         7'h40, 2'd2, 1'b1};

        reset = 1'b0; ifidINST = 32'h1234_5197; ifidPc = 32'h0;
        flush = 0; wbRegWrite = 0; wbRd = 0; wbData = 0;
        model_reset();
        #2 chk_zero("por");
        @(posedge clk); #1;
        reset = 1'b1;

        // write-back then read, and same-cycle write-through
        step(NOP, 0, 1, 5'd5, 32'hDEAD_BEEF); pc_v += 4;
        step(32'h0002_8333, 0, 0, 0, 0); pc_v += 4;
        chk("t2_rs1", idexRs1Data, 32'hDEAD_BEEF);
        chk("t2_rs2", idexRs2Data, 32'h0);
        chk("t2_ctrl", 32'(idexCtrl), 32'h40);
        chk("t2_aluop", 32'(idexAluOp), 32'h2);
        step(32'hFFF3_8413, 0, 1, 5'd7, 32'h1234); pc_v += 4;
        chk("t3_rs1", idexRs1Data, 32'h1234);
        chk("t3_imm", idexImm, 32'hFFFF_FFFF);

        // load-use: one stall cycle then the add issues
        step(LW9, 0, 0, 0, 0); pc_v += 4;
        step(ADD10, 0, 0, 0, 0);
        chk("t4_pcw", 32'(mid_pcw), 32'h1);
        chk("t4_ifw", 32'(mid_ifw), 32'h1);
        chk("t4_bub", 32'({idexCtrl, idexRd}), 32'h0);
        step(ADD10, 0, 0, 0, 0); pc_v += 4;
        chk("t4_pcw2", 32'(mid_pcw), 32'h0);
        chk("t4_rs1", 32'(idexRs1), 32'd9);
        chk("t4_rd", 32'(idexRd), 32'd10);
        chk("t4_ctrl", 32'(idexCtrl), 32'h40);

        // flush overrides a pending load-use stall
        step(LW9, 0, 0, 0, 0); pc_v += 4;
        step(32'h0024_8463, 1, 0, 0, 0); pc_v += 4;
        chk("t5_pcw", 32'(mid_pcw), 32'h0);
        chk("t5_ifw", 32'(mid_ifw), 32'h0);
        chk("t5_bub", 32'({idexCtrl, idexRd}), 32'h0);

        // x0 stays zero, including same-cycle write
        step(32'h0000_00B3, 0, 1, 5'd0, 32'hFFFF_FFFF); pc_v += 4;
        chk("x0_wt", idexRs1Data, 32'h0);
        step(32'h0000_00B3, 0, 0, 0, 0); pc_v += 4;
        chk("x0_rd", idexRs1Data, 32'h0);

        // reset in the middle of a stall
        step(32'h0012_3237, 0, 0, 0, 0); pc_v += 4;
        step(LW9, 0, 0, 0, 0); pc_v += 4;
        ifidINST = ADD10;
        #3 chk("t1_pre", 32'(pcWrite), 32'h1);
        reset = 1'b0;
        #1 chk_zero("t1");
        model_reset();
        @(posedge clk); #1;
        chk_zero("t1_hold");
        reset = 1'b1;
        step(32'h0002_8333, 0, 0, 0, 0); pc_v += 4;
        chk("t1_rfclr", idexRs1Data, 32'h0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].inst, 0, 0, 0, 0); pc_v += 4;
            chk($sformatf("tbl%0d_imm", i), idexImm, tbl[i].imm);
            chk($sformatf("tbl%0d_ctrl", i), 32'(idexCtrl),
                32'(tbl[i].ctrl));
            chk($sformatf("tbl%0d_alu", i), 32'(idexAluOp),
                32'(tbl[i].alu));
            chk($sformatf("tbl%0d_f7", i), 32'(idexFunct7b5),
                32'(tbl[i].f7));
            step(NOP, 0, 0, 0, 0); pc_v += 4;
        end

        cur = NOP;
        for (int i = 0; i < 600; i++) begin
            if (!exp_hold) begin
                cur = {7'($urandom), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 3'($urandom),
                       5'($urandom_range(0, 7)),
                       ops[$urandom_range(0, 10)]};
                pc_v += 4;
            end
            step(cur, ($urandom_range(0, 9) == 0),
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
